// File: rtl/hack_pkg.sv
// Shared word-width default and the address-width helper for the RAM bank.
package hack_pkg;

  localparam int unsigned HACK_WORD_W = 16;

  // Returns the number of bits needed to address n entries.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/register_nbit.sv
// One WIDTH-bit storage register.
// Reset has the highest priority, then clear, then load.
module register_nbit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clear) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/ram_bank_nway.sv
// DEPTH x WIDTH register bank: one-hot write demux, two combinational read muxes.
// Storage is explicit flip-flops, one register_nbit per word.
module ram_bank_nway
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = HACK_WORD_W,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] in,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] out_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] out_b
);

  logic [DEPTH-1:0] w_wr_sel;
  logic [WIDTH-1:0] w_words [DEPTH];

  always_comb begin
    w_wr_sel          = '0;
    w_wr_sel[wr_addr] = load;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    register_nbit #(
      .WIDTH(WIDTH)
    ) u_word (
      .clk  (clk),
      .rst  (rst),
      .load (w_wr_sel[gi]),
      .clear(clear),
      .d    (in),
      .q    (w_words[gi])
    );
  end

  // Reads observe register outputs only, so a write shows up after its edge.
  assign out_a = w_words[rd_addr_a];
  assign out_b = w_words[rd_addr_b];

endmodule

// File: doc/ram_bank_nway.md
RAM_BANK_NWAY -- requirements
Module: ram_bank_nway

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 16, giving the word width in bits.
- REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of words; it must be a power of two and at least 2.
- REQ-003 The block SHALL derive localparam AW = clog2(DEPTH) as the address width; AW is not overridable.
- REQ-004 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
- REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
- REQ-006 Port load, input, 1 bit: write enable for the word at wr_addr.
- REQ-007 Port clear, input, 1 bit: synchronous clear of all words.
- REQ-008 Port wr_addr, input, AW bits: write address.
- REQ-009 Port in, input, WIDTH bits: write data.
- REQ-010 Port rd_addr_a, input, AW bits: read address, port A.
- REQ-011 Port out_a, output, WIDTH bits: read data, port A.
- REQ-012 Port rd_addr_b, input, AW bits: read address, port B.
- REQ-013 Port out_b, output, WIDTH bits: read data, port B.

Function
- REQ-014 The block SHALL store DEPTH words of WIDTH bits, each held in its own register.
- REQ-015 Reads SHALL be combinational:
  - out_a = word[rd_addr_a]; out_b = word[rd_addr_b].
  - Zero-cycle latency from an address change.
- REQ-016 With load=1 and clear=0 at a rising clk edge, word[wr_addr] SHALL take the value of in; all other words hold.
- REQ-017 A written value SHALL appear on a read port only after the edge that writes it (no write-to-read bypass); during the write cycle the read port shows the old value.
- REQ-018 With clear=1 at a rising clk edge, all words SHALL become 0.
  - clear takes priority over load; a simultaneous write is discarded.
- REQ-019 With load=0 and clear=0, all words SHALL hold their values.
- REQ-020 If rd_addr_a equals rd_addr_b, out_a and out_b SHALL be identical.
- REQ-021 Any read address may equal wr_addr; the behaviour follows REQ-017.
- REQ-022 Every AW-bit address SHALL be valid, because DEPTH is a power of two; no out-of-range case exists.
- REQ-023 The write-address decode SHALL be a DEPTH-way one-hot demux of load.
- REQ-024 Each read path SHALL be a DEPTH-way WIDTH-bit mux, generalising the 8-way mux/demux of the gate set.

Reset
- REQ-025 While rst=1, all words SHALL be 0 immediately, without waiting for clk; out_a and out_b therefore read 0 in the same cycle.
- REQ-026 While rst=1, load and clear SHALL be ignored.
- REQ-027 After rst falls, the first rising edge SHALL apply the REQ-016/REQ-018 rules normally.
- REQ-028 rst asserted in the middle of a write sequence SHALL discard every earlier write; no partial state survives.

Structure
- REQ-029 Shared package hack_pkg SHALL hold:
  - HACK_WORD_W = 16, the default for WIDTH;
  - the clog2 helper function.
- REQ-030 Sub-module register_nbit SHALL implement one WIDTH-bit register:
  - ports clk, rst, load, clear, d, q;
  - priority rst > clear > load;
  - instantiated DEPTH times via generate.
- REQ-031 The block SHALL contain no memory inference primitives; storage is explicit flip-flops.

Verification (WIDTH=16, DEPTH=8)
- REQ-032 Reset:
  - Stimulus: pulse rst between clk edges, then read all 8 addresses on both ports.
  - Response: 0x0000 everywhere, visible before the next clk edge.
- REQ-033 Write/read latency:
  - Stimulus: load=1, wr_addr=5, in=0xBEEF, rd_addr_a=5.
  - Response: out_a=0x0000 before the edge, 0xBEEF after it; other addresses stay 0.
- REQ-034 Dual-port read:
  - Stimulus: write word[i]=0x1000+i for i=0..7, then sweep rd_addr_a=i and rd_addr_b=7-i.
  - Response: out_a=0x1000+i and out_b=0x1007-i; when the addresses match, the outputs are equal.
- REQ-035 Clear priority:
  - Stimulus: with memory filled, assert clear=1 and load=1 with wr_addr=3, in=0xFFFF.
  - Response: after the edge all words are 0, including word 3.
- REQ-036 Mid-sequence reset:
  - Stimulus: write 0xAAAA to address 2, then assert rst asynchronously during a cycle with load=1, wr_addr=4, in=0x5555.
  - Response: words 2 and 4 read 0 immediately and remain 0 after rst falls.
- REQ-037 Parametric build:
  - Stimulus: instantiate WIDTH=8, DEPTH=32, write 0x7F to address 31.
  - Response: address 31 reads 0x7F and address 0 reads 0x00.
